// File: rtl/arb_pkg.sv
// Shared constants and FSM state type for the 8-way round-robin arbiter.
package arb_pkg;
    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating-priority search: first set request bit at or above
// the start index, wrapping from the top index back to 0.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] winner,
    output logic             found
);

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] pos [N_REQ];

    // rot[k] is the request k positions past start; index arithmetic wraps naturally in IDX_W bits
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign pos[gi] = start + IDX_W'(gi);
            assign rot[gi] = req[pos[gi]];
        end
    endgenerate

    always_comb begin
        winner = start;
        found  = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                winner = pos[k];
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb8.sv
// Eight-requester round-robin arbiter with done/request-drop release and a
// hold-time limit that forcibly releases a grant and flags it with a pulse.
module rr_arb8
    import arb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic                 done,
    output logic [IDX_W-1:0]     gnt_idx,
    output logic                 gnt_vld,
    output logic [N_REQ-1:0]     gnt,
    output logic                 timeout
);

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] gnt_idx_reg;
    logic [IDX_W-1:0] last_idx_reg;
    logic [CNT_W-1:0] hold_cnt_reg;
    logic             timeout_reg;

    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] winner;
    logic             found;
    logic             hold_max;
    logic             rel_normal;
    logic             release_evt;

    assign start       = last_idx_reg + IDX_W'(1);
    assign hold_max    = (hold_cnt_reg == CNT_W'(TIMEOUT - 1));
    assign rel_normal  = done | ~req[gnt_idx_reg];
    assign release_evt = (state_reg == GRANT) & (rel_normal | hold_max);

    rr_pick8 u_pick (
        .req    (req),
        .start  (start),
        .winner (winner),
        .found  (found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (found)       state_next = GRANT;
            GRANT:   if (release_evt) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        gnt_vld = (state_reg == GRANT);
        gnt_idx = gnt_idx_reg;
        timeout = timeout_reg;
        gnt     = gnt_vld ? (N_REQ'(1) << gnt_idx_reg) : '0;
    end

    // Timeout flags only a release caused purely by the hold counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_idx_reg  <= '0;
            last_idx_reg <= IDX_W'(N_REQ - 1);
            hold_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            timeout_reg <= 1'b0;
            if (state_reg == IDLE) begin
                if (found) begin
                    gnt_idx_reg  <= winner;
                    hold_cnt_reg <= '0;
                end
            end else if (release_evt) begin
                last_idx_reg <= gnt_idx_reg;
                timeout_reg  <= hold_max & ~rel_normal;
            end else if (hold_cnt_reg != '1) begin
                hold_cnt_reg <= hold_cnt_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rr_arb8.sv
// Directed self-checking bench for rr_arb8 with hand-computed expectations.
module tb_rr_arb8;
    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic [7:0] gnt;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    rr_arb8 #(.TIMEOUT(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .gnt     (gnt),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
            $display("[%0t] %s obs=%0h exp=%0h ok", $time, tag, obs, exp);
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        tick();
        tick();
        check("rst_vld", {7'd0, gnt_vld}, 8'h00);
        check("rst_idx", {5'd0, gnt_idx}, 8'h00);
        check("rst_gnt", gnt, 8'h00);
        check("rst_to", {7'd0, timeout}, 8'h00);
        rst_n = 1'b1;

        // Two requesters: 0 first, then 7 after one idle cycle
        req = 8'h81;
        tick();
        check("r27_idx0", {5'd0, gnt_idx}, 8'h00);
        check("r27_gnt01", gnt, 8'h01);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("r27_idle", {7'd0, gnt_vld}, 8'h00);
        tick();
        check("r27_idx7", {5'd0, gnt_idx}, 8'h07);
        check("r27_gnt80", gnt, 8'h80);
        done = 1'b1;
        tick();
        done = 1'b0;

        // All requesting: strict rotation 0..7,0 with an idle cycle between
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("r28_vld%0d", i), {7'd0, gnt_vld}, 8'h01);
            check($sformatf("r28_idx%0d", i), {5'd0, gnt_idx}, 8'(i % 8));
            done = 1'b1;
            tick();
            done = 1'b0;
            check($sformatf("r28_gap%0d", i), {7'd0, gnt_vld}, 8'h00);
            if (i == 8) req = 8'h00;
        end
        tick();
        check("r13_stay_idle", {7'd0, gnt_vld}, 8'h00);
        check("r13_hold_idx", {5'd0, gnt_idx}, 8'h00);

        // Single requester without done: forced release after 16 cycles
        req = 8'h04;
        tick();
        for (int k = 0; k < 16; k++) begin
            check($sformatf("r29_hold%0d", k), {gnt_vld, 4'd0, gnt_idx}, 8'h82);
            check($sformatf("r29_noto%0d", k), {7'd0, timeout}, 8'h00);
            tick();
        end
        check("r29_rel_vld", {7'd0, gnt_vld}, 8'h00);
        check("r29_to_pulse", {7'd0, timeout}, 8'h01);
        tick();
        check("r29_regrant", {gnt_vld, 4'd0, gnt_idx}, 8'h82);
        check("r29_to_clear", {7'd0, timeout}, 8'h00);
        req = 8'h00;
        tick();
        check("r29_drop_idle", {7'd0, gnt_vld}, 8'h00);
        check("r29_drop_noto", {7'd0, timeout}, 8'h00);

        // done coinciding with the final hold cycle is a normal release
        req = 8'h08;
        tick();
        check("r30_idx3", {gnt_vld, 4'd0, gnt_idx}, 8'h83);
        for (int k = 1; k < 16; k++) tick();
        check("r30_cycle16", {gnt_vld, 4'd0, gnt_idx}, 8'h83);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h00;
        check("r30_rel_vld", {7'd0, gnt_vld}, 8'h00);
        check("r30_no_to", {7'd0, timeout}, 8'h00);
        tick();

        // Other requests toggling mid-grant do not disturb it
        req = 8'h20;
        tick();
        check("r31_idx5", {gnt_vld, 4'd0, gnt_idx}, 8'h85);
        req = 8'h24;
        tick();
        check("r31_hold_a", {gnt_vld, 4'd0, gnt_idx}, 8'h85);
        req = 8'h20;
        tick();
        check("r31_hold_b", {gnt_vld, 4'd0, gnt_idx}, 8'h85);
        req = 8'h04;
        tick();
        check("r31_drop_vld", {7'd0, gnt_vld}, 8'h00);
        check("r31_drop_to", {7'd0, timeout}, 8'h00);
        tick();
        check("r31_next_idx2", {gnt_vld, 4'd0, gnt_idx}, 8'h82);
        req = 8'h00;
        tick();

        // Asynchronous reset mid-grant
        req = 8'h40;
        tick();
        check("r32_idx6", {gnt_vld, 4'd0, gnt_idx}, 8'h86);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("r32_async_vld", {7'd0, gnt_vld}, 8'h00);
        check("r32_async_gnt", gnt, 8'h00);
        check("r32_async_idx", {5'd0, gnt_idx}, 8'h00);
        req = 8'h41;
        tick();
        check("r32_no_to", {7'd0, timeout}, 8'h00);
        rst_n = 1'b1;
        tick();
        check("r32_first_idx0", {gnt_vld, 4'd0, gnt_idx}, 8'h80);
        check("r32_first_gnt", gnt, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
